// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_pkg
// Purpose  : Op codes and FSM state encoding shared by the ALU op sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_op_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COMP = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Only ADD skips the negation cycle.
  function automatic logic needs_comp(input logic [1:0] op);
    return (op != OP_ADD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_twos_comp_w.sv
`default_nettype none
// ============================================================================
// Module   : twos_comp_w
// Purpose  : Combinational two's-complement negator, b = ~a + 1 (truncated).
// Revision : 1.0 - initial release
// ============================================================================
module twos_comp_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign b = ~a + ONE;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Multi-cycle ADD/SUB/NEG/ABS sequencer over one shared negator
//            and one adder, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int              MSB      = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             bmsb_q,  bmsb_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH-1:0] neg_in;
  logic [WIDTH-1:0] neg_out;
  logic [WIDTH-1:0] sum;

  twos_comp_w #(.WIDTH(WIDTH)) u_negator (
    .a (neg_in),
    .b (neg_out)
  );

  assign neg_in = (op_q == OP_SUB) ? b_q : a_q;
  assign sum    = a_q + b_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bmsb_d  = bmsb_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          bmsb_d  = in_b[MSB];
          state_d = needs_comp(in_op) ? S_COMP : S_EXEC;
        end
      end
      S_COMP: begin
        if (op_q == OP_SUB) begin
          b_d     = neg_out;
          state_d = S_EXEC;
        end else begin
          res_d   = (op_q == OP_ABS && !a_q[MSB]) ? a_q : neg_out;
          ovf_d   = (a_q == MOST_NEG);
          state_d = S_DONE;
        end
      end
      S_EXEC: begin
        res_d = sum;
        // For SUB, b_q already holds -B, so the original B sign is kept aside.
        if (op_q == OP_SUB)
          ovf_d = (a_q[MSB] != bmsb_q) && (sum[MSB] != a_q[MSB]);
        else
          ovf_d = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      bmsb_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bmsb_q  <= bmsb_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_ovf    = out_valid & ovf_q;
  assign out_zero   = out_valid & (res_q == '0);
  assign out_neg    = out_valid & res_q[MSB];

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Scoreboard bench for alu_op_sequencer with an integer-arithmetic
//            reference model, directed corner cases and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic       out_ovf;
  logic       out_zero;
  logic       out_neg;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       zero;
    logic       neg;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   rdy_mode  = 0;  // 0: always ready, 1: random, 2: stalled
  bit   seen      = 1'b0;
  bit   chk_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed arithmetic, then wrap to 8 bits.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa;
      default: r = (sa < 0) ? -sa : sa;
    endcase
    e.res  = r[7:0];
    e.ovf  = (r > 127) || (r < -128);
    e.zero = (e.res == 8'd0);
    e.neg  = e.res[7];
    e.lat  = (op == 2'd1) ? 3 : 2;
    e.acc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_ready) begin
        check("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
        chk_ready = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: result %0h with no request outstanding", out_result);
        end else begin
          if (!seen) begin
            check("latency", cyc - q[0].acc, q[0].lat - 1);
            seen = 1'b1;
          end
          check("result", {24'd0, out_result}, {24'd0, q[0].res});
          check("flags", {29'd0, out_ovf, out_zero, out_neg},
                {29'd0, q[0].ovf, q[0].zero, q[0].neg});
          check("in_ready_busy", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(q.pop_front());
            seen      = 1'b0;
            chk_ready = 1'b1;
          end
        end
      end
    end
  end

  // Called on a negedge; returns on a negedge one cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("idle_timeout", {31'd0, in_ready}, 32'd1);
        return;
      end
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    e     = model(op, a, b);
    e.acc = cyc;
    q.push_back(e);
    // Scramble inputs while busy; the latched request must be unaffected.
    @(negedge clk);
    in_op = 2'($urandom);
    in_a  = 8'($urandom);
    in_b  = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = 8'($urandom);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] corner [4];
    corner = '{8'h80, 8'h7F, 8'h00, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = 2'd0;
    in_a     = 8'd0;
    in_b     = 8'd0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {24'd0, out_result}, 32'd0);
    check("rst_flags", {29'd0, out_ovf, out_zero, out_neg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(2'd0, 8'd100, 8'd27);
    issue(2'd0, 8'd100, 8'd28);
    issue(2'd1, 8'd5,   8'd7);
    issue(2'd1, 8'h80,  8'd1);
    issue(2'd1, 8'd9,   8'd9);
    issue(2'd1, 8'd0,   8'h80);
    issue(2'd2, 8'd1,   8'd0);
    issue(2'd2, 8'h80,  8'd0);
    issue(2'd3, 8'h81,  8'd0);
    issue(2'd3, 8'h05,  8'd0);
    issue(2'd3, 8'h80,  8'd0);
    drain();

    // Hold the result for many cycles before accepting it.
    rdy_mode = 2;
    issue(2'd0, 8'd10, 8'd20);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Asynchronous reset while a SUB sits in EXEC.
    issue(2'd1, 8'd50, 8'd20);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    seen      = 1'b0;
    chk_ready = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", {24'd0, out_result}, 32'd0);
    check("midrst_flags", {29'd0, out_ovf, out_zero, out_neg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'd0, 8'd2, 8'd3);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
    end
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
